// File: rtl/aes256_ctr_framer.sv
// aes256_ctr_framer: builds the AXI-Stream beat sequence for the AES-256 CTR
// engine. Each message is key low half, key high half, counter block, one idle
// cycle, then the payload blocks passed through with a 1-cycle registered hop.
module aes256_ctr_framer #(
   parameter int BLOCK_SIZE  = 128,
   parameter int KEY_LENGTH  = 256,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    Cmd_valid,
   output logic                    Cmd_ready,
   input  logic [KEY_LENGTH-1:0]   Cmd_key,
   input  logic [BLOCK_SIZE-1:0]   Cmd_iv,
   input  logic                    Cmd_encrypt,
   input  logic                    S_axis_tvalid,
   output logic                    S_axis_tready,
   input  logic [BLOCK_SIZE-1:0]   S_axis_tdata,
   input  logic [BLOCK_SIZE/8-1:0] S_axis_tkeep,
   input  logic                    S_axis_tlast,
   output logic                    M_axis_tvalid,
   input  logic                    M_axis_tready,
   output logic [BLOCK_SIZE-1:0]   M_axis_tdata,
   output logic [BLOCK_SIZE/8-1:0] M_axis_tkeep,
   output logic                    M_axis_tlast,
   output logic                    M_axis_tuser,
   output logic                    Busy,
   output logic [COUNT_WIDTH-1:0]  Blocks_sent,
   output logic                    Keep_error
);

   typedef enum logic [2:0] {ST_IDLE, ST_KEY_LO, ST_KEY_HI, ST_COUNTER, ST_DATA} state_t;

   state_t                  state;
   logic [BLOCK_SIZE-1:0]   key_hi;
   logic [BLOCK_SIZE-1:0]   iv;
   logic                    encrypt;
   logic                    last_accepted;
   logic                    cmd_hs, s_hs, m_hs;

   // Ready signals are decoded from state so they drop in the reset cycle and
   // rise the first cycle after it; the data path itself is fully registered.
   assign Cmd_ready     = (state == ST_IDLE) && !Rst;
   assign S_axis_tready = (state == ST_DATA) && !Rst && !last_accepted &&
                          (!M_axis_tvalid || M_axis_tready);
   assign Busy          = (state != ST_IDLE);

   assign cmd_hs = Cmd_valid & Cmd_ready;
   assign s_hs   = S_axis_tvalid & S_axis_tready;
   assign m_hs   = M_axis_tvalid & M_axis_tready;

   // Framing FSM plus the output beat register, block counter and keep flag.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state         <= ST_IDLE;
         key_hi        <= '0;
         iv            <= '0;
         encrypt       <= 1'b0;
         last_accepted <= 1'b0;
         M_axis_tvalid <= 1'b0;
         M_axis_tdata  <= '0;
         M_axis_tkeep  <= '0;
         M_axis_tlast  <= 1'b0;
         M_axis_tuser  <= 1'b0;
         Blocks_sent   <= '0;
         Keep_error    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_hs) begin
                  key_hi        <= Cmd_key[KEY_LENGTH-1 -: BLOCK_SIZE];
                  iv            <= Cmd_iv;
                  encrypt       <= Cmd_encrypt;
                  Blocks_sent   <= '0;
                  Keep_error    <= 1'b0;
                  M_axis_tdata  <= Cmd_key[BLOCK_SIZE-1:0];
                  M_axis_tkeep  <= '1;
                  M_axis_tlast  <= 1'b0;
                  M_axis_tuser  <= Cmd_encrypt;
                  M_axis_tvalid <= 1'b1;
                  state         <= ST_KEY_LO;
               end
            end
            ST_KEY_LO: begin
               if (m_hs) begin
                  M_axis_tdata <= key_hi;
                  state        <= ST_KEY_HI;
               end
            end
            ST_KEY_HI: begin
               if (m_hs) begin
                  M_axis_tdata <= iv;
                  state        <= ST_COUNTER;
               end
            end
            ST_COUNTER: begin
               // Dropping valid here is the single bubble before payload.
               if (m_hs) begin
                  M_axis_tvalid <= 1'b0;
                  state         <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (s_hs) begin
                  M_axis_tdata  <= S_axis_tdata;
                  M_axis_tkeep  <= S_axis_tkeep;
                  M_axis_tlast  <= S_axis_tlast;
                  M_axis_tuser  <= encrypt;
                  M_axis_tvalid <= 1'b1;
                  if (S_axis_tlast)
                     last_accepted <= 1'b1;
                  if (!S_axis_tlast && (S_axis_tkeep != '1))
                     Keep_error <= 1'b1;
               end else if (m_hs) begin
                  M_axis_tvalid <= 1'b0;
               end
               if (m_hs) begin
                  if (Blocks_sent != '1)
                     Blocks_sent <= Blocks_sent + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                  // last_accepted blocks further S beats, so no load can collide here.
                  if (M_axis_tlast) begin
                     last_accepted <= 1'b0;
                     M_axis_tvalid <= 1'b0;
                     state         <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes256_ctr_framer.sv
// Directed bench for aes256_ctr_framer: expected M beats are queued when the
// command/payload handshakes happen and checked as they leave the DUT.
module tb_aes256_ctr_framer;

   typedef struct packed {
      logic [127:0] d;
      logic [15:0]  k;
      logic         l;
      logic         u;
   } beat_t;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic         Cmd_valid = 1'b0;
   logic         Cmd_ready;
   logic [255:0] Cmd_key = '0;
   logic [127:0] Cmd_iv = '0;
   logic         Cmd_encrypt = 1'b0;
   logic         S_axis_tvalid = 1'b0;
   logic         S_axis_tready;
   logic [127:0] S_axis_tdata = '0;
   logic [15:0]  S_axis_tkeep = '0;
   logic         S_axis_tlast = 1'b0;
   logic         M_axis_tvalid;
   logic         M_axis_tready = 1'b1;
   logic [127:0] M_axis_tdata;
   logic [15:0]  M_axis_tkeep;
   logic         M_axis_tlast;
   logic         M_axis_tuser;
   logic         Busy;
   logic [15:0]  Blocks_sent;
   logic         Keep_error;

   aes256_ctr_framer dut (
      .Clk(Clk), .Rst(Rst),
      .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready), .Cmd_key(Cmd_key),
      .Cmd_iv(Cmd_iv), .Cmd_encrypt(Cmd_encrypt),
      .S_axis_tvalid(S_axis_tvalid), .S_axis_tready(S_axis_tready),
      .S_axis_tdata(S_axis_tdata), .S_axis_tkeep(S_axis_tkeep), .S_axis_tlast(S_axis_tlast),
      .M_axis_tvalid(M_axis_tvalid), .M_axis_tready(M_axis_tready),
      .M_axis_tdata(M_axis_tdata), .M_axis_tkeep(M_axis_tkeep),
      .M_axis_tlast(M_axis_tlast), .M_axis_tuser(M_axis_tuser),
      .Busy(Busy), .Blocks_sent(Blocks_sent), .Keep_error(Keep_error)
   );

   always #5 Clk = ~Clk;

   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   int    rdy_mode = 0;          // 0: always ready, 1: 1,0,0,1 pattern, 2: never ready
   logic  cur_enc = 1'b0;
   beat_t sb[$];
   logic [3:0] rdy_pat = 4'b1001;

   localparam logic [255:0] KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   logic [127:0] pt [4];

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge Clk);
      #1;
      cyc++;
      case (rdy_mode)
         0:       M_axis_tready = 1'b1;
         1:       M_axis_tready = rdy_pat[cyc % 4];
         default: M_axis_tready = 1'b0;
      endcase
   endtask

   task automatic push_cmd_beats(input logic [255:0] key, input logic [127:0] iv, input logic enc);
      sb.push_back('{d: key[127:0],   k: 16'hFFFF, l: 1'b0, u: enc});
      sb.push_back('{d: key[255:128], k: 16'hFFFF, l: 1'b0, u: enc});
      sb.push_back('{d: iv,           k: 16'hFFFF, l: 1'b0, u: enc});
      cur_enc = enc;
   endtask

   task automatic send_cmd(input logic [255:0] key, input logic [127:0] iv, input logic enc);
      bit done = 0;
      Cmd_valid = 1'b1; Cmd_key = key; Cmd_iv = iv; Cmd_encrypt = enc;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge Clk);
         if (Cmd_ready) begin
            push_cmd_beats(key, iv, enc);
            done = 1;
         end
         tick();
      end
      Cmd_valid = 1'b0;
      chk("cmd_accept_timeout", {159'd0, done}, 160'd1);
   endtask

   task automatic drive_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
      bit done = 0;
      S_axis_tvalid = 1'b1; S_axis_tdata = d; S_axis_tkeep = k; S_axis_tlast = l;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge Clk);
         if (S_axis_tready) begin
            sb.push_back('{d: d, k: k, l: l, u: cur_enc});
            done = 1;
         end
         tick();
      end
      S_axis_tvalid = 1'b0;
      chk("payload_accept_timeout", {159'd0, done}, 160'd1);
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         tick();
         if (!Busy && sb.size() == 0) done = 1;
      end
      chk("drain_timeout", {159'd0, done}, 160'd1);
   endtask

   // Output monitor: scoreboard pop on each M handshake, hold check while stalled.
   beat_t mon_beat;
   beat_t held;
   logic  stall_prev = 1'b0;
   assign mon_beat = {M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser};

   always @(negedge Clk) begin
      if (stall_prev)
         chk("stall_hold", {14'd0, mon_beat}, {14'd0, held});
      if (M_axis_tvalid === 1'b1 && M_axis_tready === 1'b1) begin
         chk("beat_expected", {159'd0, sb.size() != 0}, 160'd1);
         if (sb.size() != 0)
            chk("m_beat", {14'd0, mon_beat}, {14'd0, sb.pop_front()});
      end
      stall_prev = (M_axis_tvalid === 1'b1) && (M_axis_tready === 1'b0) && (Rst === 1'b0);
      held = mon_beat;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
      pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;

      // Reset state
      tick(); tick();
      @(negedge Clk);
      chk("rst_m_tvalid",   {159'd0, M_axis_tvalid}, 160'd0);
      chk("rst_m_tdata",    {32'd0, M_axis_tdata}, 160'd0);
      chk("rst_cmd_ready",  {159'd0, Cmd_ready}, 160'd0);
      chk("rst_s_tready",   {159'd0, S_axis_tready}, 160'd0);
      chk("rst_busy",       {159'd0, Busy}, 160'd0);
      chk("rst_blocks",     {144'd0, Blocks_sent}, 160'd0);
      chk("rst_keep_error", {159'd0, Keep_error}, 160'd0);
      tick();
      Rst = 1'b0;
      #1;
      chk("idle_cmd_ready", {159'd0, Cmd_ready}, 160'd1);

      // Message 1: known vector, always ready; check the bubble after the counter
      send_cmd(KEY, IV, 1'b1);
      tick(); tick(); tick();
      chk("bubble_tvalid",  {159'd0, M_axis_tvalid}, 160'd0);
      chk("bubble_busy",    {159'd0, Busy}, 160'd1);
      chk("bubble_s_ready", {159'd0, S_axis_tready}, 160'd1);
      for (int i = 0; i < 4; i++) drive_beat(pt[i], 16'hFFFF, i == 3);
      wait_idle();
      chk("m1_blocks", {144'd0, Blocks_sent}, 160'd4);
      chk("m1_busy",   {159'd0, Busy}, 160'd0);
      chk("m1_keep",   {159'd0, Keep_error}, 160'd0);

      // Message 2: same message under backpressure
      rdy_mode = 1;
      send_cmd(KEY, IV, 1'b1);
      for (int i = 0; i < 4; i++) drive_beat(pt[i], 16'hFFFF, i == 3);
      wait_idle();
      chk("m2_blocks", {144'd0, Blocks_sent}, 160'd4);
      rdy_mode = 0;

      // Message 3: single partial last beat is not a keep error
      send_cmd(~KEY, ~IV, 1'b0);
      drive_beat(pt[1], 16'h00FF, 1'b1);
      wait_idle();
      chk("m3_keep",   {159'd0, Keep_error}, 160'd0);
      chk("m3_blocks", {144'd0, Blocks_sent}, 160'd1);

      // Message 4: partial non-last beat raises sticky keep error
      send_cmd(KEY, IV, 1'b0);
      drive_beat(pt[2], 16'h0FFF, 1'b0);
      drive_beat(pt[3], 16'hFFFF, 1'b1);
      wait_idle();
      tick(); tick();
      chk("m4_keep_sticky", {159'd0, Keep_error}, 160'd1);
      chk("m4_blocks",      {144'd0, Blocks_sent}, 160'd2);

      // Message 5: payload and a second command pending during the header
      send_cmd(KEY, IV, 1'b1);
      chk("m5_keep_cleared", {159'd0, Keep_error}, 160'd0);
      S_axis_tvalid = 1'b1; S_axis_tdata = pt[0]; S_axis_tkeep = 16'hFFFF; S_axis_tlast = 1'b0;
      Cmd_valid = 1'b1; Cmd_key = ~KEY; Cmd_iv = IV ^ 128'h1; Cmd_encrypt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         chk("hdr_s_ready",   {159'd0, S_axis_tready}, 160'd0);
         chk("hdr_cmd_ready", {159'd0, Cmd_ready}, 160'd0);
         tick();
      end
      drive_beat(pt[0], 16'hFFFF, 1'b0);
      drive_beat(pt[1], 16'hFFFF, 1'b1);
      Cmd_valid = 1'b1;
      @(negedge Clk);
      chk("tail_cmd_ready", {159'd0, Cmd_ready}, 160'd0);
      tick();
      @(negedge Clk);
      chk("next_cmd_ready", {159'd0, Cmd_ready}, 160'd1);
      chk("next_busy",      {159'd0, Busy}, 160'd0);
      chk("m5_drained",     {128'd0, 32'(sb.size())}, 160'd0);
      push_cmd_beats(~KEY, IV ^ 128'h1, 1'b0);
      tick();
      Cmd_valid = 1'b0;
      drive_beat(pt[2], 16'hFFFF, 1'b1);
      wait_idle();
      chk("m6_blocks", {144'd0, Blocks_sent}, 160'd1);

      // Reset while the key high beat is stalled
      send_cmd(KEY ^ 256'h5a, IV, 1'b1);
      rdy_mode = 2;
      tick();
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      #1;
      chk("mrst_tvalid",    {159'd0, M_axis_tvalid}, 160'd0);
      chk("mrst_busy",      {159'd0, Busy}, 160'd0);
      chk("mrst_cmd_ready", {159'd0, Cmd_ready}, 160'd1);
      chk("mrst_blocks",    {144'd0, Blocks_sent}, 160'd0);
      sb.delete();
      rdy_mode = 0;
      send_cmd(KEY, IV, 1'b1);
      drive_beat(pt[3], 16'hFFFF, 1'b1);
      wait_idle();
      chk("after_rst_blocks", {144'd0, Blocks_sent}, 160'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aes256_ctr_framer.md
Name: aes256_ctr_framer

Overview:
- Source-side framer that produces the AXI-Stream beat sequence consumed by the AES-256 CTR engine.
- Accepts one command per message (256-bit key, 128-bit initial counter, encrypt flag) plus a 128-bit payload stream.
- Emits, in order: key low half, key high half, counter, then payload blocks.
- Sits between the DMA/host-side payload source and the CTR core.

Parameters:
- BLOCK_SIZE, 128, data beat width in bits (fixed by AES).
- KEY_LENGTH, 256, key width in bits.
- COUNT_WIDTH, 16, width of the per-message payload block counter.

Ports:
- Clk  input  1  clock, all logic on rising edge.
- Rst  input  1  synchronous reset, active-high.
- Cmd_valid  input  1  command valid.
- Cmd_ready  output  1  command accepted when Cmd_valid & Cmd_ready.
- Cmd_key  input  KEY_LENGTH  AES-256 key.
- Cmd_iv  input  BLOCK_SIZE  initial counter block, forwarded unmodified (no byte swap).
- Cmd_encrypt  input  1  value driven on M_axis_tuser for the whole message.
- S_axis_tvalid  input  1  payload valid.
- S_axis_tready  output  1  payload ready.
- S_axis_tdata  input  BLOCK_SIZE  payload block.
- S_axis_tkeep  input  BLOCK_SIZE/8  byte enables.
- S_axis_tlast  input  1  last payload block of the message.
- M_axis_tvalid  output  1  framed beat valid.
- M_axis_tready  input  1  downstream ready.
- M_axis_tdata  output  BLOCK_SIZE  framed beat data.
- M_axis_tkeep  output  BLOCK_SIZE/8  framed beat byte enables.
- M_axis_tlast  output  1  high only on the final payload beat.
- M_axis_tuser  output  1  encrypt flag.
- Busy  output  1  high whenever state != ST_IDLE.
- Blocks_sent  output  COUNT_WIDTH  payload beats accepted downstream in the current or most recent message.
- Keep_error  output  1  sticky: a non-last payload beat arrived with tkeep != all ones.

Behaviour:
- Reset values: all M_axis_* = 0, Cmd_ready = 0 during reset cycle then 1 in ST_IDLE, S_axis_tready = 0, Busy = 0, Blocks_sent = 0, Keep_error = 0, state = ST_IDLE.
- Reset mid-message drops the message; M_axis_tvalid is 0 the cycle after Rst.
- All M_axis_* outputs are registered.
- While M_axis_tvalid & !M_axis_tready, all M_axis_* hold stable.
- States: ST_IDLE, ST_KEY_LO, ST_KEY_HI, ST_COUNTER, ST_DATA.
- ST_IDLE:
  - Cmd_ready = 1.
  - On command handshake: latch key, iv and encrypt; clear Blocks_sent and Keep_error.
  - Load the M register with {tdata = key[127:0], tkeep = all ones, tlast = 0, tuser = encrypt}, tvalid = 1 next cycle.
  - Go to ST_KEY_LO.
- ST_KEY_LO: on M handshake, load key[255:128] (tkeep all ones), go to ST_KEY_HI. Back-to-back, no bubble.
- ST_KEY_HI: on M handshake, load iv (tkeep all ones), go to ST_COUNTER.
- ST_COUNTER: on M handshake, drop M_axis_tvalid and go to ST_DATA. This gives exactly one bubble cycle before the first payload beat can appear.
- ST_DATA:
  - S_axis_tready = !last_accepted & (!M_axis_tvalid | M_axis_tready).
  - On S handshake, the M register takes tdata/tkeep/tlast from S, with tuser = latched encrypt. Latency is 1 cycle; full throughput of 1 beat/cycle.
  - On S handshake with tlast, set last_accepted; no further S beats are accepted.
  - On M handshake, Blocks_sent increments, saturating at all ones.
  - On M handshake with M_axis_tlast: clear last_accepted and M_axis_tvalid, go to ST_IDLE.
  - The next command can be accepted the following cycle.
- Cmd_ready = 0 and S_axis_tready = 0 in every state except as stated above.
- Payload beats presented outside ST_DATA are stalled, never dropped.
- Keep_error is set on an S handshake with !tlast & tkeep != all ones. The beat is still forwarded unmodified.
- An empty message is not supported: every command must be followed by at least one payload beat with tlast.

Test Plan:
- Cmd key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, iv = f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, encrypt = 1; 4 payload beats (SP800-38A F.5.5 plaintext), M_axis_tready always 1 -> M beats: 2d9810a30914dff4…? i.e. key[127:0], key[255:128], iv, bubble, 4 plaintext beats. tuser = 1 on all beats, tlast only on beat 7, Blocks_sent = 4, Busy low after the last beat.
- Same message with M_axis_tready toggled 1,0,0,1,… -> no beat lost or duplicated, tdata stable while stalled, identical beat order.
- Single payload beat with tkeep = 16'h00FF and tlast = 1 -> forwarded with tkeep 00FF and tlast 1, Keep_error = 0.
- First payload beat with tkeep = 16'h0FFF and tlast = 0 -> Keep_error = 1 and sticky until the next command; data forwarded unchanged.
- S_axis_tvalid held high during the key/counter beats, and a second Cmd_valid asserted mid-message -> S_axis_tready = 0 and Cmd_ready = 0 until the allowed states; the second command is accepted the cycle after the tlast handshake.
- Rst asserted while in ST_KEY_HI -> next cycle M_axis_tvalid = 0, Busy = 0, Cmd_ready = 1; a new command then restarts from the key low beat.
